fnd_scan_decoder: RTL and testbench

FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

---
 rtl/fnd_scan_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_decoder.sv
// Decodes a scanned 4-digit FND bus (floor / car state / countdown) into registered outputs.
// Define FND_DEC_STUCK_CHECK_EN to build the frozen-scan detector; otherwise stuck is tied low.
module fnd_scan_decoder #(
  parameter int unsigned STUCK_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fnd_com,
  input  logic [7:0] fnd_data,
  output logic       frame_valid,
  output logic [1:0] floor,
  output logic [1:0] dir,
  output logic [2:0] count,
  output logic       decode_err,
  output logic       seq_err,
  output logic [7:0] frame_cnt,
  output logic       stuck
);

  typedef enum logic {HUNT, CAPTURE} state_t;

  state_t     state_q, state_d;
  logic [3:0] com_q;
  logic [7:0] data_q;
  logic [1:0] slot_q, slot_d;
  logic       bad_q, bad_d;
  logic [2:0] cnt_stg_q, cnt_stg_d;
  logic [1:0] dir_stg_q, dir_stg_d;

  logic       frame_valid_q, frame_valid_d;
  logic       decode_err_q, decode_err_d;
  logic       seq_err_q, seq_err_d;
  logic [1:0] floor_q, floor_d;
  logic [1:0] dir_q, dir_d;
  logic [2:0] count_q, count_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic       stuck_now;
  logic       ev_good, ev_bad, ev_seq;
  logic       com_legal;
  logic [1:0] com_slot;
  logic       pat_ok;
  logic [2:0] pat_val;

  always_comb begin
    com_legal = 1'b1;
    com_slot  = 2'd0;
    case (com_q)
      4'b0111: com_slot = 2'd0;
      4'b1011: com_slot = 2'd1;
      4'b1101: com_slot = 2'd2;
      4'b1110: com_slot = 2'd3;
      default: com_legal = 1'b0;
    endcase
  end

  // Pattern meaning depends on the slot, so 8'hFC is only legal in slot 2.
  always_comb begin
    pat_ok  = 1'b0;
    pat_val = '0;
    case (com_slot)
      2'd0: pat_ok = (data_q == 8'h00);
      2'd1: begin
        case (data_q)
          8'h00: begin pat_ok = 1'b1; pat_val = 3'd0; end
          8'h60: begin pat_ok = 1'b1; pat_val = 3'd1; end
          8'hDA: begin pat_ok = 1'b1; pat_val = 3'd2; end
          8'hF2: begin pat_ok = 1'b1; pat_val = 3'd3; end
          8'h66: begin pat_ok = 1'b1; pat_val = 3'd4; end
          8'hB6: begin pat_ok = 1'b1; pat_val = 3'd5; end
          default: ;
        endcase
      end
      2'd2: begin
        case (data_q)
          8'h00: begin pat_ok = 1'b1; pat_val = 3'd0; end
          8'hFC: begin pat_ok = 1'b1; pat_val = 3'd1; end
          8'h3A: begin pat_ok = 1'b1; pat_val = 3'd2; end
          8'hC6: begin pat_ok = 1'b1; pat_val = 3'd3; end
          default: ;
        endcase
      end
      default: begin
        case (data_q)
          8'h00: begin pat_ok = 1'b1; pat_val = 3'd0; end
          8'h60: begin pat_ok = 1'b1; pat_val = 3'd1; end
          8'hDA: begin pat_ok = 1'b1; pat_val = 3'd2; end
          default: ;
        endcase
      end
    endcase
  end

`ifdef FND_DEC_STUCK_CHECK_EN
  logic [7:0] run_q, run_d;
  logic       stuck_q, stuck_d;

  // run_q is the number of cycles the registered fnd_com has held its current value.
  always_comb begin
    if (fnd_com != com_q)
      run_d = 8'd1;
    else if (run_q < 8'(STUCK_LIMIT))
      run_d = run_q + 8'd1;
    else
      run_d = run_q;
    stuck_d = (run_d >= 8'(STUCK_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      stuck_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      stuck_q <= stuck_d;
    end
  end

  assign stuck_now = stuck_d;
  assign stuck     = stuck_q;
`else
  assign stuck_now = 1'b0;
  assign stuck     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      com_q     <= 4'b1111;
      data_q    <= 8'h00;
      state_q   <= HUNT;
      slot_q    <= '0;
      bad_q     <= 1'b0;
      cnt_stg_q <= '0;
      dir_stg_q <= '0;
    end else begin
      com_q     <= fnd_com;
      data_q    <= fnd_data;
      state_q   <= state_d;
      slot_q    <= slot_d;
      bad_q     <= bad_d;
      cnt_stg_q <= cnt_stg_d;
      dir_stg_q <= dir_stg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    bad_d     = bad_q;
    cnt_stg_d = cnt_stg_q;
    dir_stg_d = dir_stg_q;
    ev_good   = 1'b0;
    ev_bad    = 1'b0;
    ev_seq    = 1'b0;
    if (stuck_now) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT: begin
          if (com_legal && com_slot == 2'd0) begin
            state_d = CAPTURE;
            slot_d  = 2'd0;
            bad_d   = ~pat_ok;
          end
        end
        CAPTURE: begin
          if (com_legal && com_slot == 2'(slot_q + 2'd1)) begin
            slot_d = com_slot;
            bad_d  = bad_q | ~pat_ok;
            if (com_slot == 2'd1) cnt_stg_d = pat_val;
            if (com_slot == 2'd2) dir_stg_d = pat_val[1:0];
            if (com_slot == 2'd3) begin
              state_d = HUNT;
              ev_good = ~bad_d;
              ev_bad  = bad_d;
            end
          end else begin
            ev_seq = 1'b1;
            if (com_legal && com_slot == 2'd0) begin
              slot_d = 2'd0;
              bad_d  = ~pat_ok;
            end else begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Floor comes straight from the slot-3 decode; the other fields were staged earlier in the frame.
  always_comb begin
    floor_d       = floor_q;
    dir_d         = dir_q;
    count_d       = count_q;
    frame_cnt_d   = frame_cnt_q;
    frame_valid_d = ev_good;
    decode_err_d  = ev_bad;
    seq_err_d     = ev_seq;
    if (ev_good) begin
      floor_d = pat_val[1:0];
      dir_d   = dir_stg_q;
      count_d = cnt_stg_q;
      if (frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      floor_q       <= '0;
      dir_q         <= '0;
      count_q       <= '0;
      frame_cnt_q   <= '0;
    end else begin
      frame_valid_q <= frame_valid_d;
      decode_err_q  <= decode_err_d;
      seq_err_q     <= seq_err_d;
      floor_q       <= floor_d;
      dir_q         <= dir_d;
      count_q       <= count_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign decode_err  = decode_err_q;
  assign seq_err     = seq_err_q;
  assign floor       = floor_q;
  assign dir         = dir_q;
  assign count       = count_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Randomized bench for fnd_scan_decoder against a frame-level reference model.
module tb_fnd_scan_decoder;
  localparam int unsigned LIMIT = 16;
`ifdef FND_DEC_STUCK_CHECK_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;
  logic       frame_valid, decode_err, seq_err, stuck;
  logic [1:0] floor, dir;
  logic [2:0] count;
  logic [7:0] frame_cnt;

  fnd_scan_decoder #(.STUCK_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .fnd_com(fnd_com), .fnd_data(fnd_data),
    .frame_valid(frame_valid), .floor(floor), .dir(dir), .count(count),
    .decode_err(decode_err), .seq_err(seq_err), .frame_cnt(frame_cnt), .stuck(stuck)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: keeps raw captured bytes and decodes the whole frame when it completes.
  int   t1[6] = '{'h00, 'h60, 'hDA, 'hF2, 'h66, 'hB6};
  int   t2[4] = '{'h00, 'hFC, 'h3A, 'hC6};
  int   t3[3] = '{'h00, 'h60, 'hDA};
  int   m_com, m_data, m_run, m_next;
  bit   m_hunt;
  int   m_bytes[4];
  int   e_floor, e_dir, e_count, e_cnt;
  bit   e_fv, e_de, e_se, e_stuck;

  function automatic int slot_of(input int c);
    case (c)
      'b0111: return 0;
      'b1011: return 1;
      'b1101: return 2;
      'b1110: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int meaning(input int slot, input int b);
    if (slot == 0) return (b == 0) ? 0 : -1;
    if (slot == 1) begin foreach (t1[i]) if (t1[i] == b) return i; end
    if (slot == 2) begin foreach (t2[i]) if (t2[i] == b) return i; end
    if (slot == 3) begin foreach (t3[i]) if (t3[i] == b) return i; end
    return -1;
  endfunction

  function automatic void finish_frame();
    bit ok = 1'b1;
    for (int s = 0; s < 4; s++) if (meaning(s, m_bytes[s]) < 0) ok = 1'b0;
    if (ok) begin
      e_fv    = 1'b1;
      e_count = meaning(1, m_bytes[1]);
      e_dir   = meaning(2, m_bytes[2]);
      e_floor = meaning(3, m_bytes[3]);
      if (e_cnt < 255) e_cnt++;
    end else begin
      e_de = 1'b1;
    end
  endfunction

  function automatic void model_step(input bit r, input int pc, input int pd);
    int s;
    e_fv = 0; e_de = 0; e_se = 0;
    if (r) begin
      m_com = 'hF; m_data = 0; m_run = 0; m_hunt = 1; m_next = 0;
      e_floor = 0; e_dir = 0; e_count = 0; e_cnt = 0; e_stuck = 0;
      return;
    end
    if (pc == m_com) begin
      if (m_run < int'(LIMIT)) m_run++;
    end else begin
      m_run = 1;
    end
    e_stuck = STUCK_EN && (m_run >= int'(LIMIT));
    s = slot_of(m_com);
    if (e_stuck) begin
      m_hunt = 1;
    end else if (m_hunt) begin
      if (s == 0) begin m_hunt = 0; m_bytes[0] = m_data; m_next = 1; end
    end else if (s == m_next) begin
      m_bytes[s] = m_data;
      if (s == 3) begin m_hunt = 1; finish_frame(); end
      else m_next++;
    end else begin
      e_se = 1;
      if (s == 0) begin m_bytes[0] = m_data; m_next = 1; end
      else m_hunt = 1;
    end
    m_com = pc; m_data = pd;
  endfunction

  task automatic cycle(input bit r, input logic [3:0] c, input logic [7:0] d);
    rst = r; fnd_com = c; fnd_data = d;
    @(posedge clk);
    model_step(r, int'(c), int'(d));
    #1;
    chk("outputs", {frame_valid, decode_err, seq_err, stuck, floor, dir, count, frame_cnt},
        {e_fv, e_de, e_se, e_stuck, 2'(e_floor), 2'(e_dir), 3'(e_count), 8'(e_cnt)});
    chk("pulse_excl", 32'(int'(frame_valid) + int'(decode_err) + int'(seq_err) <= 1), 1);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    cycle(0, 4'b0111, b0);
    cycle(0, 4'b1011, b1);
    cycle(0, 4'b1101, b2);
    cycle(0, 4'b1110, b3);
  endtask

  task automatic good_frame();
    send_frame(8'h00, 8'(t1[$urandom_range(0, 5)]), 8'(t2[$urandom_range(0, 3)]),
               8'(t3[$urandom_range(0, 2)]));
  endtask

  initial begin
    logic [7:0] b[4];
    int se_seen, fv_seen;
    logic [3:0] sc[6] = '{4'b0111, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [7:0] sd[6] = '{8'h00, 8'h60, 8'h00, 8'h60, 8'hC6, 8'hDA};

    repeat (3) cycle(1, 4'b1111, 8'h00);
    chk("reset_state", {frame_valid, decode_err, seq_err, stuck, floor, dir, count, frame_cnt}, 0);
    repeat (2) cycle(0, 4'b1111, 8'h00);

    send_frame(8'h00, 8'hB6, 8'h3A, 8'hDA);
    cycle(0, 4'b1111, 8'h00);
    chk("v1_valid", frame_valid, 1);
    chk("v1_floor", floor, 2);
    chk("v1_dir", dir, 2'b10);
    chk("v1_count", count, 5);
    chk("v1_cnt", frame_cnt, 1);

    send_frame(8'h00, 8'h60, 8'h12, 8'h60);
    cycle(0, 4'b1111, 8'h00);
    chk("bad_derr", decode_err, 1);
    chk("bad_hold", {floor, dir, count, frame_cnt}, {2'd2, 2'b10, 3'd5, 8'd1});

    cycle(0, 4'b0111, 8'h00);
    cycle(0, 4'b1011, 8'h60);
    cycle(0, 4'b1110, 8'h60);
    cycle(0, 4'b1111, 8'h00);
    chk("skip_seq", seq_err, 1);
    send_frame(8'h00, 8'h60, 8'hFC, 8'h60);
    cycle(0, 4'b1111, 8'h00);
    chk("after_seq", {frame_valid, floor, dir, count, frame_cnt}, {1'b1, 2'd1, 2'b01, 3'd1, 8'd2});

    se_seen = 0; fv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) cycle(0, sc[i], sd[i]);
      else cycle(0, 4'b1111, 8'h00);
      se_seen += int'(seq_err);
      fv_seen += int'(frame_valid);
    end
    chk("restart_seq", se_seen, 1);
    chk("restart_fv", fv_seen, 1);
    chk("restart_out", {floor, dir, count, frame_cnt}, {2'd2, 2'b11, 3'd1, 8'd3});

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        7: begin
          b[0] = 8'h00; b[1] = 8'(t1[$urandom_range(0, 5)]);
          b[2] = 8'(t2[$urandom_range(0, 3)]); b[3] = 8'(t3[$urandom_range(0, 2)]);
          b[$urandom_range(0, 3)] = 8'($urandom) | 8'h01;
          send_frame(b[0], b[1], b[2], b[3]);
        end
        8: repeat ($urandom_range(1, 3)) cycle(0, 4'($urandom), 8'($urandom));
        9: begin
          cycle(0, 4'b0111, 8'h00);
          cycle(0, 4'b1011, 8'(t1[$urandom_range(0, 5)]));
          good_frame();
        end
        default: good_frame();
      endcase
      repeat ($urandom_range(0, 3)) cycle(0, 4'b1111, 8'h00);
    end

    repeat (2) cycle(0, 4'b1111, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 4'b1011, 8'h60);
      chk("stuck_hold", stuck, STUCK_EN && i >= 16);
    end
    cycle(0, 4'b1111, 8'h00);
    chk("stuck_clear", stuck, 0);
    repeat (2) cycle(0, 4'b1111, 8'h00);

    for (int i = 0; i < 300; i++) good_frame();
    cycle(0, 4'b1111, 8'h00);
    chk("cnt_sat", frame_cnt, 255);
    cycle(0, 4'b0111, 8'h00);
    cycle(0, 4'b1011, 8'h60);
    cycle(1, 4'b1101, 8'hFC);
    chk("mid_rst", {frame_valid, decode_err, seq_err, stuck, floor, dir, count, frame_cnt}, 0);
    cycle(0, 4'b1110, 8'h60);
    repeat (3) cycle(0, 4'b1111, 8'h00);
    chk("post_rst_quiet", {frame_valid, decode_err, seq_err, frame_cnt}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
